// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state encoding and round-key slicing helper.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;
  localparam int AES_RK_W  = 1280;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FIN   = 2'd2
  } aes_state_e;

  // K1 sits at the top of the bundle and K10 at the bottom; r outside 1..10 maps to K10.
  function automatic logic [127:0] rk(input logic [1279:0] roundkeys, input logic [3:0] r);
    logic [3:0]  j;
    logic [10:0] base;
    j    = (r >= 4'd1 && r <= 4'd10) ? (4'(AES_NR) - r) : 4'd0;
    base = {j, 7'd0};
    return roundkeys[base +: 128];
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; last drops MixColumns for the final round.
module aes_round (
  input  logic [127:0] in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] out
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   xt [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;

  genvar i, c, r;

  for (i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.in(in[127-8*i -: 8]), .out(sb[i]));
  end

  // Byte index is 4*column + row; row r rotates left by r columns.
  for (c = 0; c < 4; c++) begin : g_shift_col
    for (r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  for (i = 0; i < 16; i++) begin : g_xt
    aes_xtime u_xtime (.in(sr[i]), .out(xt[i]));
    assign sr_flat[127-8*i -: 8] = sr[i];
  end

  for (c = 0; c < 4; c++) begin : g_mix
    assign mc_flat[127-32*c -: 8] = xt[4*c]   ^ xt[4*c+1] ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc_flat[119-32*c -: 8] = sr[4*c]   ^ xt[4*c+1] ^ xt[4*c+2] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc_flat[111-32*c -: 8] = sr[4*c]   ^ sr[4*c+1] ^ xt[4*c+2] ^ xt[4*c+3] ^ sr[4*c+3];
    assign mc_flat[103-32*c -: 8] = xt[4*c]   ^ sr[4*c]   ^ sr[4*c+1] ^ sr[4*c+2] ^ xt[4*c+3];
  end

  assign out = (last ? sr_flat : mc_flat) ^ rk;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational 256-entry table lookup.
module aes_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out = SBOX[{in, 3'b000} +: 8];

endmodule

// File: rtl/aes_xtime.sv
// GF(2^8) multiply-by-two with reduction polynomial 0x11B.
module aes_xtime (
  input  logic [7:0] in,
  output logic [7:0] out
);

  assign out = {in[6:0], 1'b0} ^ (in[7] ? 8'h1b : 8'h00);

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core with start/finish handshake.
// Define AES_DOUBLE_ROUND_EN to chain two rounds per cycle (5 round cycles instead of 10).
module aes_encrypt_core (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  plaintext,
  input  logic [127:0]  key,
  input  logic [1279:0] roundkeys,
  output logic [127:0]  ciphertext,
  output logic          busy,
  output logic          finish
);

  import aes_pkg::*;

  aes_state_e   state;
  logic [3:0]   round;
  logic [127:0] state_r;
  logic [127:0] round_out;

`ifdef AES_DOUBLE_ROUND_EN
  localparam logic [3:0] ROUND_STEP = 4'd2;
  localparam logic [3:0] ROUND_LAST = 4'd9;

  logic [127:0] mid;

  aes_round u_round0 (
    .in   (state_r),
    .rk   (rk(roundkeys, round)),
    .last (1'b0),
    .out  (mid)
  );

  aes_round u_round1 (
    .in   (mid),
    .rk   (rk(roundkeys, round + 4'd1)),
    .last (round == ROUND_LAST),
    .out  (round_out)
  );
`else
  localparam logic [3:0] ROUND_STEP = 4'd1;
  localparam logic [3:0] ROUND_LAST = 4'd10;

  aes_round u_round0 (
    .in   (state_r),
    .rk   (rk(roundkeys, round)),
    .last (round == ROUND_LAST),
    .out  (round_out)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      round      <= 4'd0;
      state_r    <= 128'h0;
      ciphertext <= 128'h0;
      busy       <= 1'b0;
      finish     <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state_r <= plaintext ^ key;
            round   <= 4'd1;
            state   <= ROUND;
            busy    <= 1'b1;
          end
        end
        ROUND: begin
          state_r <= round_out;
          if (round == ROUND_LAST) begin
            ciphertext <= round_out;
            round      <= 4'd0;
            state      <= FIN;
            finish     <= 1'b1;
          end else begin
            round <= round + ROUND_STEP;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed-vector bench for aes_encrypt_core using the FIPS-197 B and C.1 examples.
module tb_aes_encrypt_core;

`ifdef AES_DOUBLE_ROUND_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 11;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [0:2047] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  plaintext;
  logic [127:0]  key;
  logic [1279:0] roundkeys;
  logic [127:0]  ciphertext;
  logic          busy;
  logic          finish;

  int n_vec;
  int n_err;

  aes_encrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .roundkeys  (roundkeys),
    .ciphertext (ciphertext),
    .busy       (busy),
    .finish     (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return TB_SBOX[{x, 3'b000} +: 8];
  endfunction

  // FIPS-197 key expansion; K1 ends up in the top 128 bits.
  function automatic logic [1279:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [127:0]  kk;
    logic [1279:0] res;
    kk = k;
    for (int i = 0; i < 4; i++) begin
      w[i] = kk[127:96];
      kk   = kk << 32;
    end
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = {t[23:0], t[31:24]};
        t    = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    res = '0;
    for (int r = 1; r <= 10; r++) begin
      res = {res[1151:0], w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return res;
  endfunction

  task automatic run_op(input logic [127:0] pt, input logic [127:0] k,
                        input logic [127:0] exp_ct, input string tag);
    int cnt;
    plaintext = pt;
    key       = k;
    roundkeys = expand(k);
    start     = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 1;
    while (!finish && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, " latency"}, 128'(cnt), 128'(LAT));
    chk({tag, " ct"}, ciphertext, exp_ct);
    tick();
    chk({tag, " finish width"}, {127'h0, finish}, 128'h0);
    chk({tag, " busy after"}, {127'h0, busy}, 128'h0);
  endtask

  initial begin
    int cnt;
    int nfin, exp_n, first_e, prev_e, gap;
    bit seen;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    roundkeys = '0;
    tick();
    tick();
    chk("reset ct", ciphertext, 128'h0);
    chk("reset busy", {127'h0, busy}, 128'h0);
    chk("reset finish", {127'h0, finish}, 128'h0);
    rst = 1'b0;
    tick();

    run_op(C1_PT, C1_KEY, C1_CT, "c1");

    plaintext = B_PT;
    tick(); tick(); tick();
    chk("hold ct", ciphertext, C1_CT);

    run_op(B_PT, B_KEY, B_CT, "b");

    // start pulses while the core is mid-operation must be dropped
    plaintext = C1_PT;
    key       = C1_KEY;
    roundkeys = expand(C1_KEY);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < (LAT - 3) / 2; i++) begin
      plaintext = 128'(i) ^ 128'hdeadbeef_0badf00d_12345678_9abcdef0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    chk("noise ct midop", ciphertext, B_CT);
    chk("noise busy", {127'h0, busy}, 128'h1);
    cnt = 0;
    while (!finish && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("noise ct", ciphertext, C1_CT);
    tick();
    tick();

    // start held high: one accepted block per LAT+1 cycles
    plaintext = B_PT;
    key       = B_KEY;
    roundkeys = expand(B_KEY);
    start     = 1'b1;
    nfin = 0; first_e = -1; prev_e = -1; gap = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (finish) begin
        nfin++;
        if (first_e < 0) first_e = e;
        else gap = e - prev_e;
        prev_e = e;
      end
    end
    start = 1'b0;
    exp_n = 0;
    for (int e = LAT - 1; e < 30; e += LAT + 1) exp_n++;
    chk("held count", 128'(nfin), 128'(exp_n));
    chk("held first", 128'(first_e), 128'(LAT - 1));
    chk("held gap", 128'(gap), 128'(LAT + 1));
    cnt = 0;
    while (busy && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("held drain busy", {127'h0, busy}, 128'h0);
    chk("held ct", ciphertext, B_CT);

    // reset in the middle of an operation
    plaintext = C1_PT;
    key       = C1_KEY;
    roundkeys = expand(C1_KEY);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", {127'h0, busy}, 128'h0);
    chk("midrst ct", ciphertext, 128'h0);
    chk("midrst finish", {127'h0, finish}, 128'h0);
    seen = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (finish || busy) seen = 1'b1;
    end
    chk("midrst quiet", {127'h0, seen}, 128'h0);

    run_op(C1_PT, C1_KEY, C1_CT, "c1 rerun");

    // rst and start together: rst wins
    plaintext = B_PT;
    key       = B_KEY;
    roundkeys = expand(B_KEY);
    rst       = 1'b1;
    start     = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("prio busy", {127'h0, busy}, 128'h0);
    seen = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (finish || busy) seen = 1'b1;
    end
    chk("prio quiet", {127'h0, seen}, 128'h0);
    chk("prio ct", ciphertext, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
